// File: rtl/hbm_interface.sv
// hbm_interface
//   Per-pseudo-channel bridge between the edge-fetch stage and the HBM
//   controller. Each channel is fully independent.
//
//   Request path : upstream read addresses are buffered in a per-channel
//                  FIFO and issued to the controller one per cycle, in order,
//                  whenever the controller is not full.
//   Response path: returned HBM words pass through two register stages and
//                  are fanned out as one HBM_AWIDTH-bit edge per core.
//
// Ports
//   clk                      system clock, rising edge
//   rst                      async active-high reset vector; channel p uses
//                            bit rst[p*GROUP_CORE_NUM]
//   front_rd_hbm_edge_addr   per-channel read address from upstream
//   front_rd_hbm_edge_valid  per-channel address valid
//   hbm_controller_edge      per-channel returned data word
//   hbm_controller_valid     per-channel returned data valid
//   hbm_controller_full      controller cannot accept a request this cycle
//   stage_full               registered backpressure to upstream
//   rd_hbm_edge_addr         address issued to the controller
//   rd_hbm_edge_valid        issued address valid
//   active_v_edge            one edge word per core
//   active_v_edge_valid      per-core edge valid
module hbm_interface #(
  parameter int CORE_NUM           = 32,
  parameter int PSEUDO_CHANNEL_NUM = 2,
  parameter int GROUP_CORE_NUM     = 16,
  parameter int HBM_AWIDTH         = 32,
  parameter int HBM_DWIDTH         = 512,
  parameter int ADDR_FIFO_DEPTH    = 16,
  parameter int FULL_MARGIN        = 4
) (
  input  logic                                     clk,
  input  logic [CORE_NUM-1:0]                      rst,
  input  logic [PSEUDO_CHANNEL_NUM*HBM_AWIDTH-1:0] front_rd_hbm_edge_addr,
  input  logic [PSEUDO_CHANNEL_NUM-1:0]            front_rd_hbm_edge_valid,
  input  logic [PSEUDO_CHANNEL_NUM*HBM_DWIDTH-1:0] hbm_controller_edge,
  input  logic [PSEUDO_CHANNEL_NUM-1:0]            hbm_controller_valid,
  input  logic [PSEUDO_CHANNEL_NUM-1:0]            hbm_controller_full,
  output logic [PSEUDO_CHANNEL_NUM-1:0]            stage_full,
  output logic [PSEUDO_CHANNEL_NUM*HBM_AWIDTH-1:0] rd_hbm_edge_addr,
  output logic [PSEUDO_CHANNEL_NUM-1:0]            rd_hbm_edge_valid,
  output logic [CORE_NUM*HBM_AWIDTH-1:0]           active_v_edge,
  output logic [CORE_NUM-1:0]                      active_v_edge_valid
);

  localparam int PTR_W = $clog2(ADDR_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(ADDR_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(ADDR_FIFO_DEPTH - FULL_MARGIN);

  // Only one reset bit per channel is consumed; the rest are ignored.
  logic unused_rst;
  assign unused_rst = ^rst;

  genvar gi;
  generate
    for (gi = 0; gi < PSEUDO_CHANNEL_NUM; gi++) begin : g_ch
      logic ch_rst;
      assign ch_rst = rst[gi*GROUP_CORE_NUM];

      // ---------------- request path ----------------
      logic [HBM_AWIDTH-1:0] mem_q [ADDR_FIFO_DEPTH];
      logic [PTR_W-1:0]      wr_ptr_q;
      logic [PTR_W-1:0]      rd_ptr_q;
      logic [CNT_W-1:0]      count_q;
      logic [CNT_W-1:0]      count_d;
      logic                  push;
      logic                  pop;
      logic [HBM_AWIDTH-1:0] addr_q;
      logic                  addr_valid_q;
      logic                  stage_full_q;

      // Pop decision uses the pre-edge count, so an address pushed this edge
      // cannot leave before the next one.
      assign push = front_rd_hbm_edge_valid[gi] && (count_q != DEPTH_CNT);
      assign pop  = (count_q != '0) && !hbm_controller_full[gi];

      always_comb begin
        count_d = count_q;
        case ({push, pop})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
      end

      // Storage needs no reset: validity is tracked by the pointers/count.
      always_ff @(posedge clk) begin
        if (push) begin
          mem_q[wr_ptr_q] <= front_rd_hbm_edge_addr[gi*HBM_AWIDTH +: HBM_AWIDTH];
        end
      end

      always_ff @(posedge clk or posedge ch_rst) begin
        if (ch_rst) begin
          wr_ptr_q     <= '0;
          rd_ptr_q     <= '0;
          count_q      <= '0;
          addr_q       <= '0;
          addr_valid_q <= 1'b0;
          stage_full_q <= 1'b0;
        end else begin
          if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
          if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
          count_q <= count_d;
          // Registered against the post-edge count so the flag always
          // reflects the FIFO occupancy currently held.
          stage_full_q <= (count_d >= FULL_LEVEL);
          if (pop) begin
            addr_q       <= mem_q[rd_ptr_q];
            addr_valid_q <= 1'b1;
          end else begin
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
          end
        end
      end

      assign stage_full[gi]                                  = stage_full_q;
      assign rd_hbm_edge_addr[gi*HBM_AWIDTH +: HBM_AWIDTH]   = addr_q;
      assign rd_hbm_edge_valid[gi]                           = addr_valid_q;

      // ---------------- response path ----------------
      logic [HBM_DWIDTH-1:0] s1_data_q;
      logic                  s1_valid_q;
      logic [HBM_DWIDTH-1:0] edge_q;
      logic                  edge_valid_q;

      always_ff @(posedge clk or posedge ch_rst) begin
        if (ch_rst) begin
          s1_data_q    <= '0;
          s1_valid_q   <= 1'b0;
          edge_q       <= '0;
          edge_valid_q <= 1'b0;
        end else begin
          s1_data_q    <= hbm_controller_edge[gi*HBM_DWIDTH +: HBM_DWIDTH];
          s1_valid_q   <= hbm_controller_valid[gi];
          // Gate the data so idle cycles present zeros to the cores.
          edge_q       <= s1_valid_q ? s1_data_q : '0;
          edge_valid_q <= s1_valid_q;
        end
      end

      genvar ki;
      for (ki = 0; ki < GROUP_CORE_NUM; ki++) begin : g_core
        assign active_v_edge[(gi*GROUP_CORE_NUM+ki)*HBM_AWIDTH +: HBM_AWIDTH] =
          edge_q[ki*HBM_AWIDTH +: HBM_AWIDTH];
        assign active_v_edge_valid[gi*GROUP_CORE_NUM+ki] = edge_valid_q;
      end
    end
  endgenerate

endmodule

// File: tb/tb_hbm_interface.sv
// Self-checking bench for hbm_interface (default parameters).
module tb_hbm_interface;

  logic          clk;
  logic [31:0]   rst;
  logic [63:0]   f_addr;
  logic [1:0]    f_valid;
  logic [1023:0] c_edge;
  logic [1:0]    c_valid;
  logic [1:0]    c_full;
  logic [1:0]    stage_full;
  logic [63:0]   rd_hbm_edge_addr;
  logic [1:0]    rd_hbm_edge_valid;
  logic [1023:0] active_v_edge;
  logic [31:0]   active_v_edge_valid;

  int checks;
  int errors;

  hbm_interface dut (
    .clk                     (clk),
    .rst                     (rst),
    .front_rd_hbm_edge_addr  (f_addr),
    .front_rd_hbm_edge_valid (f_valid),
    .hbm_controller_edge     (c_edge),
    .hbm_controller_valid    (c_valid),
    .hbm_controller_full     (c_full),
    .stage_full              (stage_full),
    .rd_hbm_edge_addr        (rd_hbm_edge_addr),
    .rd_hbm_edge_valid       (rd_hbm_edge_valid),
    .active_v_edge           (active_v_edge),
    .active_v_edge_valid     (active_v_edge_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0]   mf [2][1024];
  int            mhead [2];
  int            mcnt [2];
  logic [511:0]  s1_data [2];
  logic          s1_valid [2];

  logic [63:0]   exp_rd_addr;
  logic [1:0]    exp_rd_valid;
  logic [1:0]    exp_stage_full;
  logic [1023:0] exp_edge;
  logic [31:0]   exp_edge_valid;

  task automatic model_reset(input int p);
    mhead[p] = 0;
    mcnt[p]  = 0;
    s1_data[p]  = '0;
    s1_valid[p] = 1'b0;
    exp_rd_addr[p*32 +: 32]     = '0;
    exp_rd_valid[p]             = 1'b0;
    exp_stage_full[p]           = 1'b0;
    exp_edge[p*512 +: 512]      = '0;
    exp_edge_valid[p*16 +: 16]  = '0;
  endtask

  task automatic model_edge();
    int pre;
    for (int p = 0; p < 2; p++) begin
      if (rst[p*16]) begin
        model_reset(p);
      end else begin
        pre = mcnt[p];
        if (pre > 0 && !c_full[p]) begin
          exp_rd_addr[p*32 +: 32] = mf[p][mhead[p]];
          exp_rd_valid[p] = 1'b1;
          mhead[p] = (mhead[p] + 1) % 1024;
          mcnt[p]  = mcnt[p] - 1;
        end else begin
          exp_rd_addr[p*32 +: 32] = '0;
          exp_rd_valid[p] = 1'b0;
        end
        if (f_valid[p] && pre < 16) begin
          mf[p][(mhead[p] + mcnt[p]) % 1024] = f_addr[p*32 +: 32];
          mcnt[p] = mcnt[p] + 1;
        end
        exp_stage_full[p] = (mcnt[p] >= 12);
        exp_edge[p*512 +: 512]     = s1_valid[p] ? s1_data[p] : '0;
        exp_edge_valid[p*16 +: 16] = {16{s1_valid[p]}};
        s1_data[p]  = c_edge[p*512 +: 512];
        s1_valid[p] = c_valid[p];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic int first_diff(input logic [1023:0] a, input logic [1023:0] b);
    for (int k = 0; k < 32; k++) begin
      if (a[k*32 +: 32] !== b[k*32 +: 32]) return k;
    end
    return 0;
  endfunction

  task automatic idle_inputs();
    f_addr  = '0;
    f_valid = '0;
    c_edge  = '0;
    c_valid = '0;
    c_full  = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int k;
    rst = '1;
    idle_inputs();
    for (int p = 0; p < 2; p++) model_reset(p);
    repeat (10) step();
    rst = '0;
    step();
    checks++;
    if (rd_hbm_edge_valid !== 2'b00 || rd_hbm_edge_addr !== 64'd0) begin
      errors++;
      $display("FAIL reset_rd got valid=%b addr=%h exp valid=00 addr=0", rd_hbm_edge_valid, rd_hbm_edge_addr);
    end
    checks++;
    if (stage_full !== 2'b00) begin
      errors++;
      $display("FAIL reset_stage_full got %b exp 00", stage_full);
    end
    checks++;
    if (active_v_edge !== exp_edge || active_v_edge_valid !== 32'd0) begin
      errors++;
      k = first_diff(active_v_edge, exp_edge);
      $display("FAIL reset_edge slice %0d got %h valid %h exp %h valid 0", k,
               active_v_edge[k*32 +: 32], active_v_edge_valid, exp_edge[k*32 +: 32]);
    end
  endtask

  task automatic test_addr_basic();
    f_addr  = {32'd1, 32'd0};
    f_valid = 2'b11;
    step();
    checks++;
    if (rd_hbm_edge_valid !== 2'b00) begin
      errors++;
      $display("FAIL addr_latency got valid %b exp 00", rd_hbm_edge_valid);
    end
    idle_inputs();
    step();
    checks++;
    if (rd_hbm_edge_addr !== {32'd1, 32'd0} || rd_hbm_edge_valid !== 2'b11) begin
      errors++;
      $display("FAIL addr_issue got addr %h valid %b exp addr %h valid 11",
               rd_hbm_edge_addr, rd_hbm_edge_valid, {32'd1, 32'd0});
    end
    checks++;
    if (active_v_edge_valid !== 32'd0 || active_v_edge !== 1024'd0) begin
      errors++;
      $display("FAIL addr_no_edge got edge_valid %h exp 0", active_v_edge_valid);
    end
    step();
    checks++;
    if (rd_hbm_edge_valid !== 2'b00 || rd_hbm_edge_addr !== 64'd0) begin
      errors++;
      $display("FAIL addr_drop got valid %b addr %h exp 00/0", rd_hbm_edge_valid, rd_hbm_edge_addr);
    end
  endtask

  task automatic test_data_basic();
    logic [1023:0] pat;
    int k;
    pat = {32{32'h00000101}};
    c_edge  = pat;
    c_valid = 2'b11;
    step();
    checks++;
    if (active_v_edge_valid !== 32'd0) begin
      errors++;
      $display("FAIL data_latency got valid %h exp 0", active_v_edge_valid);
    end
    idle_inputs();
    step();
    checks++;
    if (active_v_edge !== pat || active_v_edge_valid !== 32'hFFFF_FFFF) begin
      errors++;
      k = first_diff(active_v_edge, pat);
      $display("FAIL data_fanout slice %0d got %h valid %h exp %h valid ffffffff", k,
               active_v_edge[k*32 +: 32], active_v_edge_valid, pat[k*32 +: 32]);
    end
    checks++;
    if (rd_hbm_edge_valid !== 2'b00) begin
      errors++;
      $display("FAIL data_no_rd got %b exp 00", rd_hbm_edge_valid);
    end
    step();
    checks++;
    if (active_v_edge_valid !== 32'd0 || active_v_edge !== 1024'd0) begin
      errors++;
      $display("FAIL data_drop got valid %h exp 0", active_v_edge_valid);
    end
  endtask

  task automatic test_backpressure();
    c_full = 2'b01;
    for (int i = 0; i < 13; i++) begin
      f_addr  = {32'd0, 32'(i)};
      f_valid = 2'b01;
      step();
      checks++;
      if (stage_full !== exp_stage_full || stage_full[0] !== (i + 1 >= 12)) begin
        errors++;
        $display("FAIL bp_fill_stage_full push %0d got %b exp %b", i, stage_full, exp_stage_full);
      end
      checks++;
      if (rd_hbm_edge_valid !== 2'b00) begin
        errors++;
        $display("FAIL bp_no_issue push %0d got %b exp 00", i, rd_hbm_edge_valid);
      end
    end
    idle_inputs();
    for (int i = 0; i < 13; i++) begin
      step();
      checks++;
      if (rd_hbm_edge_valid !== 2'b01 || rd_hbm_edge_addr[31:0] !== 32'(i)
          || rd_hbm_edge_addr !== exp_rd_addr) begin
        errors++;
        $display("FAIL bp_drain %0d got addr %h valid %b exp addr %h valid 01",
                 i, rd_hbm_edge_addr, rd_hbm_edge_valid, exp_rd_addr);
      end
      checks++;
      if (stage_full !== exp_stage_full) begin
        errors++;
        $display("FAIL bp_drain_stage_full %0d got %b exp %b", i, stage_full, exp_stage_full);
      end
    end
    step();
    checks++;
    if (rd_hbm_edge_valid !== 2'b00) begin
      errors++;
      $display("FAIL bp_empty got %b exp 00", rd_hbm_edge_valid);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    for (int b = 0; b < 6; b++) begin
      if (b < 4) begin
        for (int w = 0; w < 32; w++) c_edge[w*32 +: 32] = 32'h1000 * (b + 1) + 32'(w);
        c_valid = 2'b11;
      end else begin
        c_edge  = '0;
        c_valid = 2'b00;
      end
      step();
      checks++;
      if (active_v_edge !== exp_edge || active_v_edge_valid !== exp_edge_valid) begin
        errors++;
        k = first_diff(active_v_edge, exp_edge);
        $display("FAIL b2b beat %0d slice %0d got %h valid %h exp %h valid %h", b, k,
                 active_v_edge[k*32 +: 32], active_v_edge_valid, exp_edge[k*32 +: 32], exp_edge_valid);
      end
      if (b >= 1 && b <= 4) begin
        checks++;
        if (active_v_edge[31:0] !== 32'h1000 * b || active_v_edge_valid !== 32'hFFFF_FFFF) begin
          errors++;
          $display("FAIL b2b_core0 beat %0d got %h exp %h", b, active_v_edge[31:0], 32'h1000 * b);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    c_full = 2'b01;
    for (int i = 0; i < 5; i++) begin
      f_addr  = {$urandom, $urandom};
      f_valid = 2'b11;
      if (i == 3) begin
        for (int w = 0; w < 32; w++) c_edge[w*32 +: 32] = $urandom;
        c_valid = 2'b11;
      end else begin
        c_edge  = '0;
        c_valid = 2'b00;
      end
      step();
    end
    f_valid = '0;
    c_valid = '0;
    rst = '1;
    for (int p = 0; p < 2; p++) model_reset(p);
    #1;
    checks++;
    if (rd_hbm_edge_valid !== 2'b00 || rd_hbm_edge_addr !== 64'd0 || stage_full !== 2'b00
        || active_v_edge_valid !== 32'd0 || active_v_edge !== 1024'd0) begin
      errors++;
      $display("FAIL midreset_async got rd_valid %b stage_full %b edge_valid %h exp all 0",
               rd_hbm_edge_valid, stage_full, active_v_edge_valid);
    end
    step();
    step();
    rst = '0;
    c_full = 2'b00;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (rd_hbm_edge_valid !== 2'b00 || active_v_edge_valid !== 32'd0) begin
        errors++;
        $display("FAIL midreset_stale cyc %0d got rd_valid %b edge_valid %h exp 00/0",
                 i, rd_hbm_edge_valid, active_v_edge_valid);
      end
    end
  endtask

  task automatic test_random();
    int k;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        c_full[p]  = ($urandom_range(0, 3) == 0);
        // Mostly honour backpressure; occasionally overrun to exercise drops.
        f_valid[p] = exp_stage_full[p] ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1);
        f_addr[p*32 +: 32] = $urandom;
        c_valid[p] = ($urandom_range(0, 2) != 0);
      end
      for (int w = 0; w < 32; w++) c_edge[w*32 +: 32] = $urandom;
      step();
      checks++;
      if (rd_hbm_edge_addr !== exp_rd_addr || rd_hbm_edge_valid !== exp_rd_valid) begin
        errors++;
        $display("FAIL rand_rd cyc %0d got addr %h valid %b exp addr %h valid %b",
                 cyc, rd_hbm_edge_addr, rd_hbm_edge_valid, exp_rd_addr, exp_rd_valid);
      end
      checks++;
      if (stage_full !== exp_stage_full) begin
        errors++;
        $display("FAIL rand_stage_full cyc %0d got %b exp %b", cyc, stage_full, exp_stage_full);
      end
      checks++;
      if (active_v_edge !== exp_edge || active_v_edge_valid !== exp_edge_valid) begin
        errors++;
        k = first_diff(active_v_edge, exp_edge);
        $display("FAIL rand_edge cyc %0d slice %0d got %h valid %h exp %h valid %h", cyc, k,
                 active_v_edge[k*32 +: 32], active_v_edge_valid, exp_edge[k*32 +: 32], exp_edge_valid);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = '1;
    idle_inputs();
    test_reset();
    test_addr_basic();
    test_data_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish within 200000");
    $fatal(1, "timeout");
  end

endmodule
